load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-wide memory port of the load/store unit.
// The LSU takes the slave side; the requester and memory model take the master side.
interface load_store_unit_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddress;
    logic [31:0] ReqData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespError;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemEnableWrite;
    logic [31:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqData,
        input  RespReady, MemReadData,
        output ReqReady, RespValid, RespData, RespError,
        output MemAddress, MemWriteData, MemEnableWrite
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqData,
        output RespReady, MemReadData,
        input  ReqReady, RespValid, RespData, RespError,
        input  MemAddress, MemWriteData, MemEnableWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-wide memory with a combinational read port.
// Stores are read-modify-write: the addressed lanes are merged into the word read back.
module load_store_unit #(
    parameter int unsigned ADDRESS_LIMIT = 32'h80
) (
    input logic              Clock,
    input logic              Reset,
    load_store_unit_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] data_q, data_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        req_fault;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        req_fault = 1'b0;
        unique case (bus_io.ReqSize)
            2'b00:   req_fault = 1'b0;
            2'b01:   req_fault = bus_io.ReqAddress[0];
            2'b10:   req_fault = (bus_io.ReqAddress[1:0] != 2'b00);
            default: req_fault = 1'b1;
        endcase
        if (bus_io.ReqAddress >= ADDRESS_LIMIT) req_fault = 1'b1;
    end

    // Lane extraction and merge both work on the word currently on MemReadData.
    always_comb begin
        byte_sel    = bus_io.MemReadData[{offset_q, 3'b000} +: 8];
        half_sel    = offset_q[1] ? bus_io.MemReadData[31:16] : bus_io.MemReadData[15:0];
        load_value  = bus_io.MemReadData;
        merged_word = bus_io.MemReadData;
        unique case (size_q)
            2'b00: begin
                load_value = {{24{signed_q & byte_sel[7]}}, byte_sel};
                merged_word[{offset_q, 3'b000} +: 8] = data_q[7:0];
            end
            2'b01: begin
                load_value = {{16{signed_q & half_sel[15]}}, half_sel};
                if (offset_q[1]) merged_word[31:16] = data_q[15:0];
                else             merged_word[15:0]  = data_q[15:0];
            end
            default: begin
                load_value  = bus_io.MemReadData;
                merged_word = data_q;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        offset_d     = offset_q;
        data_d       = data_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.ReqValid) begin
                    write_d  = bus_io.ReqWrite;
                    size_d   = bus_io.ReqSize;
                    signed_d = bus_io.ReqSigned;
                    offset_d = bus_io.ReqAddress[1:0];
                    data_d   = bus_io.ReqData;
                    if (req_fault) begin
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                        state_d      = StResp;
                    end else begin
                        resp_error_d = 1'b0;
                        mem_addr_d   = {bus_io.ReqAddress[31:2], 2'b00};
                        state_d      = StRead;
                    end
                end
            end
            StRead: begin
                if (write_q) begin
                    mem_wdata_d = merged_word;
                    state_d     = StWrite;
                end else begin
                    resp_data_d = load_value;
                    state_d     = StResp;
                end
            end
            StWrite: begin
                resp_data_d = '0;
                state_d     = StResp;
            end
            StResp: begin
                if (bus_io.RespReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            offset_q     <= 2'b00;
            data_q       <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            offset_q     <= offset_d;
            data_q       <= data_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus_io.ReqReady       = (state_q == StIdle);
    assign bus_io.RespValid      = (state_q == StResp);
    assign bus_io.RespData       = resp_data_q;
    assign bus_io.RespError      = resp_error_q;
    assign bus_io.MemAddress     = mem_addr_q;
    assign bus_io.MemWriteData   = mem_wdata_q;
    // Reset gates the strobe directly so a reset landing in WRITE commits nothing.
    assign bus_io.MemEnableWrite = (state_q == StWrite) && !Reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic
// compared against a byte-lane arithmetic model of memory.
module tb_load_store_unit;

    logic Clock;
    logic Reset;
    load_store_unit_if bus ();

    load_store_unit #(.ADDRESS_LIMIT(32'h80)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .bus_io (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [31:0] mem     [0:31];
    logic [31:0] ref_mem [0:31];
    int          n_writes = 0;
    int          n_vec    = 0;
    int          n_err    = 0;

    assign bus.MemReadData = mem[bus.MemAddress[6:2]];

    always @(posedge Clock) begin
        if (bus.MemEnableWrite) begin
            mem[bus.MemAddress[6:2]] <= bus.MemWriteData;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: treat memory as little-endian bytes, access = (1<<size) bytes at addr.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic err, output logic [31:0] res);
        logic [31:0] word;
        logic [31:0] mask;
        int          sh;
        int          nbytes;
        err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
              || (a >= 32'h80);
        res = '0;
        if (err) return;
        nbytes = 1 << sz;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        sh     = 8 * int'(a % 4);
        word   = ref_mem[a / 4];
        if (w) begin
            ref_mem[a / 4] = (word & ~(mask << sh)) | ((d & mask) << sh);
        end else begin
            res = (word >> sh) & mask;
            if (sg && nbytes < 4 && res[8 * nbytes - 1]) res = res | ~mask;
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        int          w0;
        model(w, sz, sg, a, d, exp_err, exp_data);
        exp_lat = exp_err ? 1 : (w ? 3 : 2);
        w0 = n_writes;
        bus.ReqValid   = 1'b1;
        bus.ReqWrite   = w;
        bus.ReqSize    = sz;
        bus.ReqSigned  = sg;
        bus.ReqAddress = a;
        bus.ReqData    = d;
        @(posedge Clock);
        #1;
        bus.ReqValid = 1'b0;
        lat = 1;
        while (!bus.RespValid && lat < 8) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("resp_error", bus.RespError, exp_err);
        check_eq("resp_data", bus.RespData, exp_data);
        check_eq("write_count", n_writes - w0, (w && !exp_err) ? 1 : 0);
        if (w && !exp_err) check_eq("mem_word", mem[a[6:2]], ref_mem[a[6:2]]);
        @(posedge Clock);
        #1;
        check_eq("resp_one_cycle", bus.RespValid, 1'b0);
        check_eq("back_to_idle", bus.ReqReady, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        e;
        logic [31:0] exp_data;
        int          w0;
        int          lat;

        for (int i = 0; i < 32; i++) begin
            mem[i]     = 32'(4 * i);
            ref_mem[i] = 32'(4 * i);
        end
        Reset          = 1'b1;
        bus.ReqValid   = 1'b0;
        bus.ReqWrite   = 1'b0;
        bus.ReqSize    = 2'b00;
        bus.ReqSigned  = 1'b0;
        bus.ReqAddress = '0;
        bus.ReqData    = '0;
        bus.RespReady  = 1'b1;

        repeat (2) @(posedge Clock);
        #1;
        check_eq("rst_resp_valid", bus.RespValid, 1'b0);
        check_eq("rst_resp_data", bus.RespData, 32'h0);
        check_eq("rst_resp_error", bus.RespError, 1'b0);
        check_eq("rst_mem_addr", bus.MemAddress, 32'h0);
        check_eq("rst_mem_wdata", bus.MemWriteData, 32'h0);
        check_eq("rst_mem_we", bus.MemEnableWrite, 1'b0);
        Reset = 1'b0;
        #1;
        check_eq("rst_req_ready", bus.ReqReady, 1'b1);

        // Directed scenarios
        do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
        check_eq("sb_word4", mem[4], 32'h0000_AB10);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_8001);
        check_eq("sh_word2", mem[2], 32'h8001_0008);
        do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678);
        do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h1234_5678);

        // Response back-pressure: held response, second request ignored
        model(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, e, exp_data);
        w0 = n_writes;
        bus.ReqValid   = 1'b1;
        bus.ReqWrite   = 1'b0;
        bus.ReqSize    = 2'd2;
        bus.ReqSigned  = 1'b0;
        bus.ReqAddress = 32'h0C;
        bus.RespReady  = 1'b0;
        @(posedge Clock);
        #1;
        bus.ReqValid = 1'b0;
        lat = 1;
        while (!bus.RespValid && lat < 8) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        check_eq("stall_latency", lat, 2);
        bus.ReqValid   = 1'b1;
        bus.ReqWrite   = 1'b1;
        bus.ReqAddress = 32'h10;
        bus.ReqData    = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            check_eq("stall_valid", bus.RespValid, 1'b1);
            check_eq("stall_data", bus.RespData, exp_data);
            check_eq("stall_ready", bus.ReqReady, 1'b0);
        end
        bus.ReqValid  = 1'b0;
        bus.RespReady = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("stall_release_valid", bus.RespValid, 1'b0);
        check_eq("stall_release_ready", bus.ReqReady, 1'b1);
        check_eq("stall_no_write", n_writes - w0, 0);

        // Reset landing in the WRITE cycle of a store
        w0 = n_writes;
        bus.ReqValid   = 1'b1;
        bus.ReqWrite   = 1'b1;
        bus.ReqSize    = 2'd2;
        bus.ReqAddress = 32'h04;
        bus.ReqData    = 32'hDEAD_BEEF;
        @(posedge Clock);
        #1;
        bus.ReqValid = 1'b0;
        @(posedge Clock);
        #1;
        check_eq("we_in_write", bus.MemEnableWrite, 1'b1);
        Reset = 1'b1;
        #1;
        check_eq("we_forced_off", bus.MemEnableWrite, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check_eq("rst_write_word1", mem[1], 32'h0000_0004);
        check_eq("rst_write_count", n_writes - w0, 0);
        check_eq("rst_write_idle", bus.ReqReady, 1'b1);
        check_eq("rst_write_valid", bus.RespValid, 1'b0);
        @(posedge Clock);
        #1;
        check_eq("rst_write_no_resp", bus.RespValid, 1'b0);

        // Randomized traffic, biased toward aligned in-range addresses
        for (int i = 0; i < 200; i++) begin
            a  = 32'($urandom_range(0, 32'h8F));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        for (int i = 0; i < 32; i++) check_eq("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
